hazard_unit: RTL

- Producer side of the execute-stage operand-forwarding interface. Generates the 2-bit forward selects that the execute stage consumes (00 = register-file read, 01 = result_m, 10 = result_w).
- Generates the stall and flush controls for the 5-stage pipeline.
- Tracks the destination register and write-enable of instructions in E, M and W in its own shadow pipeline registers, so the decode stage only supplies per-instruction fields once.
- Includes a saturating bubble counter for performance monitoring.

---
 rtl/hazard_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: operand-forwarding selects, stall/flush control and a
// saturating bubble counter for a 5-stage in-order pipeline. The unit keeps
// its own copy of the E/M/W destination info, so decode supplies each
// instruction's fields only once, while that instruction is in D.
//
// Forward select encoding: 2'b00 register file, 2'b01 result_m, 2'b10 result_w.
module hazard_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_d_i,
  input  logic                      reg_write_d_i,
  input  logic                      load_d_i,
  input  logic                      pc_src_e_i,
  input  logic                      dmem_stall_i,
  output logic [1:0]                forward1_e_o,
  output logic [1:0]                forward2_e_o,
  output logic                      stall_f_o,
  output logic                      stall_d_o,
  output logic                      stall_e_o,
  output logic                      stall_m_o,
  output logic                      stall_w_o,
  output logic                      flush_d_o,
  output logic                      flush_e_o,
  output logic [CNT_WIDTH-1:0]      bubble_count_o
);

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b10;

  // Shadow pipeline state for the instructions currently in E, M and W.
  logic [REG_ADDR_WIDTH-1:0] rs1_e, rs2_e, rd_e;
  logic                      reg_write_e, load_e;
  logic [REG_ADDR_WIDTH-1:0] rd_m;
  logic                      reg_write_m;
  logic [REG_ADDR_WIDTH-1:0] rd_w;
  logic                      reg_write_w;

  logic load_use;

  // Forward selects: the youngest in-flight writer (M before W) wins; x0 never forwards.
  always_comb begin
    forward1_e_o = FWD_RF;
    forward2_e_o = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e))
      forward1_e_o = FWD_M;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e))
      forward1_e_o = FWD_W;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e))
      forward2_e_o = FWD_M;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e))
      forward2_e_o = FWD_W;
  end

  // Load-use detection: conservative, D's source fields are matched whether used or not.
  always_comb begin
    load_use = load_e && (rd_e != '0) &&
               ((rd_e == rs1_d_i) || (rd_e == rs2_d_i));
  end

  // Stall/flush priority: memory stall freezes everything, then a taken
  // branch squashes D and E (a branch held in E under a memory stall is
  // serviced once the stall drops), then a load-use inserts one bubble.
  always_comb begin
    stall_f_o = 1'b0;
    stall_d_o = 1'b0;
    stall_e_o = 1'b0;
    stall_m_o = 1'b0;
    stall_w_o = 1'b0;
    flush_d_o = 1'b0;
    flush_e_o = 1'b0;
    if (dmem_stall_i) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      stall_e_o = 1'b1;
      stall_m_o = 1'b1;
      stall_w_o = 1'b1;
    end else if (pc_src_e_i) begin
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
    end else if (load_use) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      flush_e_o = 1'b1;
    end
  end

  // Advance the shadow pipeline; a flushed E slot becomes an all-zero bubble.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd_e        <= '0;
      reg_write_e <= 1'b0;
      load_e      <= 1'b0;
      rd_m        <= '0;
      reg_write_m <= 1'b0;
      rd_w        <= '0;
      reg_write_w <= 1'b0;
    end else if (!dmem_stall_i) begin
      rd_w        <= rd_m;
      reg_write_w <= reg_write_m;
      rd_m        <= rd_e;
      reg_write_m <= reg_write_e;
      if (flush_e_o) begin
        rs1_e       <= '0;
        rs2_e       <= '0;
        rd_e        <= '0;
        reg_write_e <= 1'b0;
        load_e      <= 1'b0;
      end else begin
        rs1_e       <= rs1_d_i;
        rs2_e       <= rs2_d_i;
        rd_e        <= rd_d_i;
        reg_write_e <= reg_write_d_i;
        load_e      <= load_d_i;
      end
    end
  end

  // Count every bubble injected into E, saturating at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      bubble_count_o <= '0;
    else if (flush_e_o && (bubble_count_o != '1))
      bubble_count_o <= bubble_count_o + CNT_WIDTH'(1);
  end

endmodule
